shift_sub_divider: RTL and testbench
====================================

Name: shift_sub_divider

Overview:
- Sequential restoring divider: unsigned N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.
- Arithmetic inverse of the shift-add multiplier datapath: same A/Q register pair, same start/ready handshake, one shift and one subtract state per quotient bit.
- Sits beside the multiplier and is driven by the same slow clock from the counter block.

Parameters:
N, 4, operand width in bits; quotient and remainder are also N bits.

Ports:
clock  input  1  system clock; all state updates on rising edge
n_reset  input  1  asynchronous active-low reset
start  input  1  level request; sampled only in IDLE
dividend  input  N  unsigned dividend; captured at the start edge
divisor  input  N  unsigned divisor; captured at the start edge
quotient  output  N  registered result; held until the next completion
remainder  output  N  registered result; held until the next completion
ready  output  1  high when idle or done; low while busy
div_by_zero  output  1  high alongside results when the captured divisor was 0

Behaviour:
- Reset (n_reset low, asynchronous):
  - State goes to IDLE immediately.
  - A=0, Q=0, M=0, count=0.
  - quotient=0, remainder=0, div_by_zero=0, ready=1.
  - Reset mid-operation aborts the operation; no partial result reaches the outputs.
- Internal registers: A (N+1 bits, MSB is sign), Q (N bits), M (N bits), count (ceil(log2(N+1)) bits).
- States: IDLE, SHIFT, SUB, DONE.
- IDLE, start=1 at an edge:
  - M<=divisor, Q<=dividend, A<=0, count<=N, ready<=0.
  - If divisor==0, go to DONE.
  - Otherwise go to SHIFT.
- IDLE, start=0: hold all state.
- SHIFT: {A,Q} <= {A,Q}<<1, Q[0]<=0, then go to SUB.
- SUB:
  - Compute T=A-{1'b0,M} in N+1 bits.
  - If T[N]==1 (negative): A is unchanged (restore) and Q[0]<=0.
  - Otherwise: A<=T and Q[0]<=1.
  - count<=count-1.
  - If count==1, go to DONE; otherwise go to SHIFT.
- Entering DONE from SUB:
  - quotient<=Q with final bit included, remainder<=A[N-1:0], div_by_zero<=0, ready<=1.
- Entering DONE on divide-by-zero:
  - quotient<=all ones, remainder<=dividend, div_by_zero<=1, ready<=1.
- DONE:
  - Stay in DONE while start=1; a held start never retriggers.
  - Go to IDLE when start=0.
  - ready stays 1 in both DONE and IDLE.
- Latency:
  - Start sampled at edge k.
  - ready falls after edge k.
  - Results valid and ready rises after edge k+2N (8 edges for N=4).
  - Divide-by-zero case: results after edge k+1.
- Inputs:
  - dividend and divisor are ignored after the start edge; changes mid-operation have no effect.
  - start is ignored in SHIFT and SUB.
- Outputs are registered. They change only on reset or on entry to DONE, so the previous result stays visible throughout a new operation.
- Invariants: A never exceeds M-1 after a SUB. remainder < divisor whenever div_by_zero=0.

Test Plan:
- Reset, then dividend=7, divisor=5, start pulsed -> ready low for 8 cycles, then quotient=1, remainder=2, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=15, divisor=15 -> quotient=1, remainder=0. Then dividend=0, divisor=3 -> quotient=0, remainder=0.
- dividend=5, divisor=0 -> one cycle later quotient=4'hF, remainder=5, div_by_zero=1, ready=1. The next valid divide clears div_by_zero.
- start held high for 20 cycles with 13/4 -> exactly one operation: quotient=3, remainder=1. No restart until start drops for at least one cycle and rises again.
- Start 14/3, assert n_reset low at cycle 4 of the operation -> outputs zero, ready=1 asynchronously. After release, 14/3 completes with quotient=4, remainder=2.
- Change dividend/divisor every cycle during an operation begun with 9/2 -> result is quotient=4, remainder=1. Previous outputs stay stable until completion.

Source files
------------

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: unsigned N-bit dividend / divisor -> quotient, remainder.
// Uses an A/Q register pair with one SHIFT and one SUB state per quotient bit.
module shift_sub_divider #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         ready,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;

  state_t         state, state_nxt;
  logic [N:0]     a_reg;
  logic [N-1:0]   q_reg;
  logic [N-1:0]   m_reg;
  logic [CW-1:0]  count;
  logic [N:0]     diff;
  logic [N-1:0]   q_sub;
  logic           last_bit;

  assign diff     = a_reg - {1'b0, m_reg};
  assign last_bit = (count == CW'(1));

  // Q after the trial subtraction: LSB is 1 when the difference is non-negative.
  always_comb begin
    q_sub    = q_reg;
    q_sub[0] = ~diff[N];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks execute in.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : SHIFT;
      SHIFT:   state_nxt = SUB;
      SUB:     state_nxt = last_bit ? DONE : SHIFT;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ready       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= divisor;
            q_reg <= dividend;
            a_reg <= '0;
            count <= CW'(N);
            ready <= 1'b0;
          end
        end
        SHIFT: {a_reg, q_reg} <= {a_reg[N-1:0], q_reg, 1'b0};
        SUB: begin
          q_reg <= q_sub;
          if (!diff[N]) a_reg <= diff;
          count <= count - CW'(1);
          if (last_bit) begin
            quotient    <= q_sub;
            remainder   <= diff[N] ? a_reg[N-1:0] : diff[N-1:0];
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
          end
        end
        DONE: begin
          // ready is only still low here on the divide-by-zero path; Q still holds the dividend.
          if (!ready) begin
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
            ready       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider (N=4): hand-computed quotients/remainders,
// latency, divide-by-zero, held start, mid-operation reset and input changes.
module tb_shift_sub_divider;

  logic       clock;
  logic       n_reset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       ready;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;
  logic [3:0] prev_q = '0;
  logic [3:0] prev_r = '0;

  shift_sub_divider #(.N(4)) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full operation with start pulsed for one edge; optionally scrambles inputs while busy.
  task automatic run_op(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                        input logic [3:0] exp_q, input logic [3:0] exp_r, input bit scramble);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check({tag, "_busy_ready"}, {7'd0, ready}, 8'd0);
      check({tag, "_hold_q"}, {4'd0, quotient}, {4'd0, prev_q});
      check({tag, "_hold_r"}, {4'd0, remainder}, {4'd0, prev_r});
      if (scramble) begin
        dividend = 4'($urandom_range(15, 0));
        divisor  = 4'($urandom_range(15, 0));
      end
    end
    tick();
    check({tag, "_ready"}, {7'd0, ready}, 8'd1);
    check({tag, "_q"}, {4'd0, quotient}, {4'd0, exp_q});
    check({tag, "_r"}, {4'd0, remainder}, {4'd0, exp_r});
    check({tag, "_dbz"}, {7'd0, div_by_zero}, 8'd0);
    prev_q = exp_q;
    prev_r = exp_r;
    tick();
  endtask

  initial begin
    n_reset  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_q", {4'd0, quotient}, 8'd0);
    check("rst_r", {4'd0, remainder}, 8'd0);
    check("rst_ready", {7'd0, ready}, 8'd1);
    check("rst_dbz", {7'd0, div_by_zero}, 8'd0);
    n_reset = 1'b1;
    tick();

    run_op("d7_5", 4'd7, 4'd5, 4'd1, 4'd2, 1'b0);
    run_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run_op("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    run_op("d0_3", 4'd0, 4'd3, 4'd0, 4'd0, 1'b0);

    // Divide by zero: ready low one cycle, then all-ones quotient and remainder = dividend.
    dividend = 4'd5;
    divisor  = 4'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("dbz_busy_ready", {7'd0, ready}, 8'd0);
    check("dbz_hold_q", {4'd0, quotient}, {4'd0, prev_q});
    tick();
    check("dbz_q", {4'd0, quotient}, 8'h0F);
    check("dbz_r", {4'd0, remainder}, 8'd5);
    check("dbz_flag", {7'd0, div_by_zero}, 8'd1);
    check("dbz_ready", {7'd0, ready}, 8'd1);
    prev_q = 4'hF;
    prev_r = 4'd5;
    tick();

    // Start held for 20 edges with 13/4: exactly one operation, no retrigger.
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    dividend = 4'd9;
    divisor  = 4'd2;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check("held_busy_ready", {7'd0, ready}, 8'd0);
    end
    tick();
    check("held_q", {4'd0, quotient}, 8'd3);
    check("held_r", {4'd0, remainder}, 8'd1);
    check("held_dbz_clr", {7'd0, div_by_zero}, 8'd0);
    check("held_ready", {7'd0, ready}, 8'd1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("held_no_retrig_ready", {7'd0, ready}, 8'd1);
      check("held_no_retrig_q", {4'd0, quotient}, 8'd3);
    end
    start = 1'b0;
    tick();
    check("held_release_ready", {7'd0, ready}, 8'd1);
    prev_q = 4'd3;
    prev_r = 4'd1;
    tick();

    run_op("d9_2_scr", 4'd9, 4'd2, 4'd4, 4'd1, 1'b1);

    // Reset during the fourth cycle of a 14/3 operation.
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("abort_busy_ready", {7'd0, ready}, 8'd0);
    repeat (3) tick();
    #3;
    n_reset = 1'b0;
    #1;
    check("abort_q", {4'd0, quotient}, 8'd0);
    check("abort_r", {4'd0, remainder}, 8'd0);
    check("abort_ready", {7'd0, ready}, 8'd1);
    check("abort_dbz", {7'd0, div_by_zero}, 8'd0);
    tick();
    check("abort_hold_ready", {7'd0, ready}, 8'd1);
    #3;
    n_reset = 1'b1;
    tick();
    prev_q = 4'd0;
    prev_r = 4'd0;
    run_op("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
